// File: rtl/axi_apb_pkg.sv
// Shared AXI read-response constants and the read-channel FSM state type.
package axi_apb_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE,
        BURST
    } rd_state_t;

endpackage

// File: rtl/axi_r_slice.sv
// One-entry registered R-channel slice; loads whenever it is empty or being drained,
// so a continuous rready=1 stream runs without bubbles.
module axi_r_slice #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  avail,
    input  logic [ID_WIDTH-1:0]   in_id,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_resp,
    input  logic                  in_last,
    output logic                  load,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast
);

    assign load = avail & (~rvalid | rready);

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            rid    <= '0;
            rdata  <= '0;
            rresp  <= '0;
            rlast  <= 1'b0;
        end else if (load) begin
            rvalid <= 1'b1;
            rid    <= in_id;
            rdata  <= in_data;
            rresp  <= in_resp;
            rlast  <= in_last;
        end else if (rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_rdata_resp.sv
// AXI read-data responder: walks one burst descriptor at a time, popping beats from a
// read-data FIFO onto the R channel. Build option R_OUTPUT_REG_EN adds a registered R slice.
module axi_rdata_resp
    import axi_apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [7:0]            cmd_len,
    output logic                  cmd_ready,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH+1:0] fifo_data,
    output logic                  fifo_rd,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast
);

    rd_state_t             state_q, state_d;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_cnt;
    logic                  beat_avail;
    logic                  beat_last;

    assign cmd_ready  = (state_q == IDLE);
    assign beat_avail = (state_q == BURST) & ~fifo_empty;
    assign beat_last  = (beat_cnt == len_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = BURST;
            BURST:   if (fifo_rd && beat_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // beat_cnt wraps only on the pop of beat 256, which is already the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rid_q    <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_valid && cmd_ready) begin
                rid_q    <= cmd_id;
                len_q    <= cmd_len;
                beat_cnt <= '0;
            end else if (fifo_rd) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

`ifdef R_OUTPUT_REG_EN
    axi_r_slice #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_slice (
        .clk     (clk),
        .rst     (rst),
        .avail   (beat_avail),
        .in_id   (rid_q),
        .in_data (fifo_data[DATA_WIDTH-1:0]),
        .in_resp (fifo_data[DATA_WIDTH+1:DATA_WIDTH]),
        .in_last (beat_last),
        .load    (fifo_rd),
        .rvalid  (rvalid),
        .rready  (rready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast)
    );
`else
    // Payload is gated by rvalid so an idle channel reads as all zeros.
    assign rvalid  = beat_avail;
    assign fifo_rd = rvalid & rready;
    assign rid     = rvalid ? rid_q : '0;
    assign rdata   = rvalid ? fifo_data[DATA_WIDTH-1:0] : '0;
    assign rresp   = rvalid ? fifo_data[DATA_WIDTH+1:DATA_WIDTH] : 2'b00;
    assign rlast   = rvalid & beat_last;
`endif

endmodule
